// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin share of one mem cmd/resp port; grant is combinational (zero latency) and locked until mem yumi.
// Commands stall when max_outstanding_p tags are in flight; responses stall on the head owner's ready.
module bp_me_mem_cmd_arbiter #(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 576,
  parameter int max_outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] req_cmd_i,
  input  logic [num_req_p-1:0]             req_cmd_v_i,
  output logic [num_req_p-1:0]             req_cmd_yumi_o,
  output logic [msg_width_p-1:0]           req_resp_o,
  output logic [num_req_p-1:0]             req_resp_v_o,
  input  logic [num_req_p-1:0]             req_resp_ready_i,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic                             idle_o
);
  localparam int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int tag_ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int tag_cnt_w_lp  = $clog2(max_outstanding_p + 1);
  localparam logic [num_req_p-1:0] one_lp = num_req_p'(1);

  typedef enum logic {e_unlocked, e_locked} state_e;

  state_e                    state_r, state_n;
  logic [lg_num_req_lp-1:0]  ptr_r, lock_idx_r, rr_idx, grant_idx, head_idx;
  logic                      rr_v, grant_v, cmd_fire, resp_fire;
  int                        rr_cand;

  logic [lg_num_req_lp-1:0]  tag_mem_r [max_outstanding_p];
  logic [tag_ptr_w_lp-1:0]   rd_ptr_r, wr_ptr_r;
  logic [tag_cnt_w_lp-1:0]   count_r;
  logic                      tag_full, tag_v;

  // Scan from the highest offset down so the requester closest to the pointer wins.
  always_comb begin
    rr_v    = 1'b0;
    rr_idx  = '0;
    rr_cand = 0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      rr_cand = (int'(ptr_r) + k) % num_req_p;
      if (req_cmd_v_i[rr_cand]) begin
        rr_v   = 1'b1;
        rr_idx = lg_num_req_lp'(rr_cand);
      end
    end
  end

  assign grant_idx      = (state_r == e_locked) ? lock_idx_r : rr_idx;
  assign grant_v        = (state_r == e_locked) ? req_cmd_v_i[lock_idx_r] : rr_v;
  assign mem_cmd_v_o    = grant_v & ~tag_full & ~reset_i;
  assign mem_cmd_o      = req_cmd_i[grant_idx*msg_width_p +: msg_width_p];
  assign cmd_fire       = mem_cmd_v_o & mem_cmd_yumi_i;
  assign req_cmd_yumi_o = cmd_fire ? (one_lp << grant_idx) : '0;

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_unlocked: if (mem_cmd_v_o & ~mem_cmd_yumi_i) state_n = e_locked;
      e_locked:   if (mem_cmd_yumi_i) state_n = e_unlocked;
      default:    state_n = e_unlocked;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= e_unlocked;
      lock_idx_r <= '0;
      ptr_r      <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == e_unlocked && state_n == e_locked)
        lock_idx_r <= grant_idx;
      if (cmd_fire)
        ptr_r <= (grant_idx == lg_num_req_lp'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // In-order tag FIFO; full blocks a push even when a pop happens in the same cycle.
  assign tag_full = (count_r == tag_cnt_w_lp'(max_outstanding_p));
  assign tag_v    = (count_r != '0);
  assign head_idx = tag_mem_r[rd_ptr_r];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (cmd_fire)
        wr_ptr_r <= (wr_ptr_r == tag_ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_r + 1'b1;
      if (resp_fire)
        rd_ptr_r <= (rd_ptr_r == tag_ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_r + 1'b1;
      if (cmd_fire & ~resp_fire)
        count_r <= count_r + 1'b1;
      else if (resp_fire & ~cmd_fire)
        count_r <= count_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cmd_fire)
      tag_mem_r[wr_ptr_r] <= grant_idx;
  end

  assign req_resp_o      = mem_resp_i;
  assign req_resp_v_o    = (mem_resp_v_i & tag_v & ~reset_i) ? (one_lp << head_idx) : '0;
  assign resp_fire       = mem_resp_v_i & tag_v & req_resp_ready_i[head_idx] & ~reset_i;
  assign mem_resp_yumi_o = resp_fire;
  assign idle_o          = ~tag_v & (state_r == e_unlocked);

  a_lock_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_r == e_locked) |-> req_cmd_v_i[lock_idx_r]);
  a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_cmd_yumi_i |-> mem_cmd_v_o);
  a_resp_needs_tag: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_resp_v_i |-> tag_v);

endmodule
